pixel_packer: RTL and testbench
===============================

# pixel_packer

Parametrised pixel-to-word packer for the TinyML hardware-accelerator datapath. It takes a stream of RGB888 or 8-bit grayscale pixels and packs their bytes densely into OUT_BYTES-wide words for the DMA/accelerator bus. It adds valid/ready backpressure on both sides, end-of-frame flush with padding, byte-keep flags and a last-word marker. The block sits between the camera/preprocess pipeline and the memory write path.

## Interface
- OUT_BYTES, 4: output word width in bytes. Legal values are 4, 8 and 16.
- PACK_MODE, 0: byte order and pixel format.
  - 0: RGB, emits in_rgb[7:0], then [15:8], then [23:16].
  - 1: BGR, emits [23:16], then [15:8], then [7:0].
  - 2: gray, emits in_gray, one byte per pixel.
- PAD_BYTE, 8'h00: filler value for unused byte lanes in the flush word.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  pixel present.
- in_ready  out  1  pixel accepted when in_valid & in_ready.
- in_rgb  in  24  RGB888 pixel. Used in modes 0 and 1.
- in_gray  in  8  grayscale pixel. Used in mode 2.
- in_eof  in  1  qualifies the accepted pixel as the last pixel of the frame.
- out_data  out  8*OUT_BYTES  packed word. Byte lane 0 holds the earliest byte.
- out_keep  out  OUT_BYTES  per-lane valid flags. All ones except on a padded flush word.
- out_last  out  1  marks the final word of the frame.
- out_valid  out  1  word present.
- out_ready  in  1  word consumed when out_valid & out_ready.
- frame_done  out  1  single-cycle pulse when the out_last word is consumed.

## Operation
- BPP (bytes per pixel) is 3 in modes 0 and 1, and 1 in mode 2.
- Accumulator: OUT_BYTES+2 bytes plus a fill counter of 0..OUT_BYTES+2. Between cycles, fill ≤ OUT_BYTES-1.
- Accept: the pixel's BPP bytes are appended at lane index fill, giving fill_new = fill + BPP.
- If fill_new ≥ OUT_BYTES:
  - Lanes [0..OUT_BYTES-1] load into the output register with out_keep all ones and out_valid set.
  - The remaining fill_new - OUT_BYTES bytes (0..2) shift down to lane 0.
- Output register: a single stage that holds data, keep and last stable while out_valid & !out_ready.
- in_ready = (state == RUN) & (!out_valid | out_ready). This is combinational from out_ready by design.
- State machine with two states, RUN and FLUSH. RUN is the reset state.
- RUN, accepted pixel with in_eof=1:
  - fill_new < OUT_BYTES: emit a padded word (keep bits [fill_new-1:0] set, other lanes PAD_BYTE), out_last=1, fill←0, stay in RUN.
  - fill_new == OUT_BYTES: emit the full word with out_last=1, fill←0, stay in RUN.
  - fill_new > OUT_BYTES: emit the full word with out_last=0, keep the remainder, go to FLUSH.
- FLUSH: when the output register is free (!out_valid | out_ready), emit the remainder padded, with out_last=1 and keep = (1<<fill)-1. Then fill←0 and go to RUN. in_ready=0 throughout FLUSH.
- Partial data with no in_eof stays in the accumulator indefinitely. There is no timeout.
- frame_done = out_valid & out_ready & out_last, registered, so it pulses one cycle later.

## Timing
- Reset values: out_valid=0, out_last=0, out_keep=0, out_data=0, frame_done=0, fill=0, state=RUN.
- in_ready is high in the cycle after rst deasserts.
- Latency: the word completed by the accept in cycle N appears with out_valid=1 in cycle N+1.
- Throughput: one pixel per cycle with out_ready held high.
  - Gray mode: one word every OUT_BYTES cycles.
  - RGB modes: 3 words per OUT_BYTES pixels when OUT_BYTES=4.
- Simultaneous consume and refill: in the same cycle, the output register takes the new word and out_valid stays 1 with no bubble.
- FLUSH costs at most one extra cycle of in_ready=0 when out_ready=1.
- rst mid-frame or mid-FLUSH discards all accumulated bytes and any pending word. No out_last or frame_done is produced for the aborted frame.
- in_eof is ignored when in_valid & in_ready is false.

## Test plan
- OUT_BYTES=4, mode 0, pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A, out_ready=1 → three words 0x04030201, 0x08070605, 0x0C0B0A09, keep 0xF. The last word arrives the cycle after the 4th pixel.
- OUT_BYTES=4, mode 1, pixels 0x030201 then 0x060504 with in_eof → word 0x06010203 (keep 0xF, last=0), FLUSH, then word 0x00000405 (keep 0x3, last=1), then a frame_done pulse.
- OUT_BYTES=4, mode 2, gray 0x11, 0x22, 0x33, 0x44, 0x55 with in_eof on 0x55 → words 0x44332211 (keep 0xF) and 0x00000055 (keep 0x1, last=1).
- OUT_BYTES=8, mode 0, 8 pixels with in_eof on the 8th → three full words, the third with last=1. No FLUSH occurs.
- Backpressure: out_ready=0 for 5 cycles while a word is pending → in_ready=0, and out_data/out_keep/out_last stay stable. When out_ready returns to 1, words resume with no loss or duplication.
- Assert rst for one cycle while in FLUSH → out_valid=0, no frame_done, and in_ready=1 on the next cycle. The next frame packs from lane 0.

Source files
------------

// File: rtl/pixel_packer.sv
// rtl/pixel_packer.sv - packs RGB888/gray pixel bytes densely into OUT_BYTES-wide words
// with frame flush, padding, keep flags and a one-word output register.
module pixel_packer #(
  parameter int         OUT_BYTES = 4,
  parameter int         PACK_MODE = 0,
  parameter logic [7:0] PAD_BYTE  = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [23:0]            in_rgb,
  input  logic [7:0]             in_gray,
  input  logic                   in_eof,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic [OUT_BYTES-1:0]   out_keep,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_done
);

  localparam int ACC = OUT_BYTES + 2;
  localparam int FW  = $clog2(OUT_BYTES + 3);
  localparam int BPP = (PACK_MODE == 2) ? 1 : 3;
  localparam logic [FW-1:0] OB_F  = FW'(OUT_BYTES);
  localparam logic [FW-1:0] BPP_F = FW'(BPP);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                 state_q;
  logic [7:0]             acc_q [ACC];
  logic [FW-1:0]          fill_q;
  logic [8*OUT_BYTES-1:0] data_q;
  logic [OUT_BYTES-1:0]   keep_q;
  logic                   last_q;
  logic                   valid_q;
  logic                   done_q;

  logic [7:0]             pix [3];
  logic [7:0]             acc_d [ACC];
  logic [FW-1:0]          fill_d;
  logic                   accept;
  logic                   out_free;
  logic [8*OUT_BYTES-1:0] full_word;
  logic [8*OUT_BYTES-1:0] pad_word;
  logic [8*OUT_BYTES-1:0] flush_word;
  logic [OUT_BYTES-1:0]   pad_keep;
  logic [OUT_BYTES-1:0]   flush_keep;

  assign out_free = !valid_q | out_ready;
  assign in_ready = (state_q == RUN) & out_free;
  assign accept   = in_valid & in_ready;

  always_comb begin
    pix[0] = in_rgb[7:0];
    pix[1] = in_rgb[15:8];
    pix[2] = in_rgb[23:16];
    case (PACK_MODE)
      1: begin
        pix[0] = in_rgb[23:16];
        pix[1] = in_rgb[15:8];
        pix[2] = in_rgb[7:0];
      end
      2: begin
        pix[0] = in_gray;
        pix[1] = 8'h00;
        pix[2] = 8'h00;
      end
      default: ;
    endcase
  end

  // Pixel bytes land at lanes fill..fill+BPP-1 of the accumulator.
  always_comb begin
    fill_d = fill_q + BPP_F;
    for (int j = 0; j < ACC; j++) begin
      acc_d[j] = acc_q[j];
      for (int i = 0; i < BPP; i++) begin
        if (FW'(j) == fill_q + FW'(i)) acc_d[j] = pix[i];
      end
    end
  end

  always_comb begin
    full_word  = '0;
    pad_word   = '0;
    flush_word = '0;
    pad_keep   = '0;
    flush_keep = '0;
    for (int j = 0; j < OUT_BYTES; j++) begin
      full_word[8*j +: 8]  = acc_d[j];
      pad_keep[j]          = FW'(j) < fill_d;
      flush_keep[j]        = FW'(j) < fill_q;
      pad_word[8*j +: 8]   = (FW'(j) < fill_d) ? acc_d[j] : PAD_BYTE;
      flush_word[8*j +: 8] = (FW'(j) < fill_q) ? acc_q[j] : PAD_BYTE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fill_q  <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int j = 0; j < ACC; j++) acc_q[j] <= 8'h00;
    end else begin
      done_q <= valid_q & out_ready & last_q;
      if (valid_q & out_ready) valid_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (accept) begin
            if (fill_d >= OB_F) begin
              data_q  <= full_word;
              keep_q  <= '1;
              valid_q <= 1'b1;
              last_q  <= in_eof && (fill_d == OB_F);
              fill_q  <= fill_d - OB_F;
              for (int k = 0; k < 2; k++) acc_q[k] <= acc_d[OUT_BYTES+k];
              if (in_eof && (fill_d != OB_F)) state_q <= FLUSH;
            end else if (in_eof) begin
              data_q  <= pad_word;
              keep_q  <= pad_keep;
              last_q  <= 1'b1;
              valid_q <= 1'b1;
              fill_q  <= '0;
            end else begin
              for (int j = 0; j < ACC; j++) acc_q[j] <= acc_d[j];
              fill_q <= fill_d;
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            data_q  <= flush_word;
            keep_q  <= flush_keep;
            last_q  <= 1'b1;
            valid_q <= 1'b1;
            fill_q  <= '0;
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign out_data   = data_q;
  assign out_keep   = keep_q;
  assign out_last   = last_q;
  assign out_valid  = valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_packer.sv
// tb/tb_pixel_packer.sv - directed vector bench for pixel_packer across four configurations.
module tb_pixel_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_eof, out_ready;
  logic [23:0] in_rgb;
  logic [7:0]  in_gray;
  logic [3:0]  rdy, ov, ol, fd;
  logic [31:0] d0, d1, d2;
  logic [63:0] d3;
  logic [3:0]  k0, k1, k2;
  logic [7:0]  k3;

  pixel_packer #(.OUT_BYTES(4), .PACK_MODE(0), .PAD_BYTE(8'h00)) u_rgb4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_rgb(in_rgb),
    .in_gray(in_gray), .in_eof(in_eof), .out_data(d0), .out_keep(k0), .out_last(ol[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .frame_done(fd[0]));
  pixel_packer #(.OUT_BYTES(4), .PACK_MODE(1), .PAD_BYTE(8'h00)) u_bgr4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_rgb(in_rgb),
    .in_gray(in_gray), .in_eof(in_eof), .out_data(d1), .out_keep(k1), .out_last(ol[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .frame_done(fd[1]));
  pixel_packer #(.OUT_BYTES(4), .PACK_MODE(2), .PAD_BYTE(8'h00)) u_gray4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_rgb(in_rgb),
    .in_gray(in_gray), .in_eof(in_eof), .out_data(d2), .out_keep(k2), .out_last(ol[2]),
    .out_valid(ov[2]), .out_ready(out_ready), .frame_done(fd[2]));
  pixel_packer #(.OUT_BYTES(8), .PACK_MODE(0), .PAD_BYTE(8'h00)) u_rgb8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .in_rgb(in_rgb),
    .in_gray(in_gray), .in_eof(in_eof), .out_data(d3), .out_keep(k3), .out_last(ol[3]),
    .out_valid(ov[3]), .out_ready(out_ready), .frame_done(fd[3]));

  typedef struct packed {
    int                sel;
    int                npix;
    logic [7:0][23:0]  pix;
    bit                eof;
    int                nw;
    bit                lat;
    logic [2:0][63:0]  w;
    logic [2:0][7:0]   k;
    logic [2:0]        l;
  } vec_t;

  vec_t vecs [6];

  int total = 0, bad = 0, cyc = 0, cur_sel = 0, last_acc = 0, fd_cnt = 0;
  logic [63:0] q_data [$];
  logic [7:0]  q_keep [$];
  logic        q_last [$];
  int          q_cyc  [$];

  function automatic logic [63:0] get_data(int s);
    case (s)
      0: return {32'h0, d0};
      1: return {32'h0, d1};
      2: return {32'h0, d2};
      default: return d3;
    endcase
  endfunction

  function automatic logic [7:0] get_keep(int s);
    case (s)
      0: return {4'h0, k0};
      1: return {4'h0, k1};
      2: return {4'h0, k2};
      default: return k3;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ov[cur_sel] && out_ready) begin
      q_data.push_back(get_data(cur_sel));
      q_keep.push_back(get_keep(cur_sel));
      q_last.push_back(ol[cur_sel]);
      q_cyc.push_back(cyc);
    end
    if (fd[cur_sel]) fd_cnt <= fd_cnt + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    in_eof = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [23:0] p, input bit eof);
    int n;
    in_valid = 1'b1;
    in_rgb = p;
    in_gray = p[7:0];
    in_eof = eof;
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy[cur_sel]) break;
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected 1");
        in_valid = 1'b0;
        in_eof = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    in_valid = 1'b0;
    in_eof = 1'b0;
  endtask

  task automatic drain_and_check_words(input int qb, input int nw, input logic [2:0][63:0] w,
                                       input logic [2:0][7:0] k, input logic [2:0] l);
    repeat (6) @(posedge clk);
    #1;
    chk("word_count", 64'(q_data.size() - qb), 64'(nw));
    for (int i = 0; i < nw; i++) begin
      if (qb + i < q_data.size()) begin
        chk("word_data", q_data[qb+i], w[i]);
        chk("word_keep", 64'(q_keep[qb+i]), 64'(k[i]));
        chk("word_last", 64'(q_last[qb+i]), 64'(l[i]));
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int qb, fb;
    rst = 1'b1; in_valid = 1'b0; in_eof = 1'b0; out_ready = 1'b1;
    in_rgb = '0; in_gray = '0;

    for (int v = 0; v < 6; v++) begin
      vecs[v] = '0;
      for (int i = 0; i < 8; i++)
        vecs[v].pix[i] = {8'(3*i+3), 8'(3*i+2), 8'(3*i+1)};
    end
    vecs[0].sel = 0; vecs[0].npix = 4; vecs[0].eof = 0; vecs[0].nw = 3; vecs[0].lat = 1;
    vecs[0].w[0] = 64'h04030201; vecs[0].w[1] = 64'h08070605; vecs[0].w[2] = 64'h0C0B0A09;
    vecs[0].k = {8'h0F, 8'h0F, 8'h0F}; vecs[0].l = 3'b000;
    vecs[1].sel = 1; vecs[1].npix = 2; vecs[1].eof = 1; vecs[1].nw = 2;
    vecs[1].w[0] = 64'h06010203; vecs[1].w[1] = 64'h00000405;
    vecs[1].k[0] = 8'h0F; vecs[1].k[1] = 8'h03; vecs[1].l = 3'b010;
    vecs[2].sel = 2; vecs[2].npix = 5; vecs[2].eof = 1; vecs[2].nw = 2;
    for (int i = 0; i < 5; i++) vecs[2].pix[i] = {16'h0, 8'(17*(i+1))};
    vecs[2].w[0] = 64'h44332211; vecs[2].w[1] = 64'h00000055;
    vecs[2].k[0] = 8'h0F; vecs[2].k[1] = 8'h01; vecs[2].l = 3'b010;
    vecs[3].sel = 3; vecs[3].npix = 8; vecs[3].eof = 1; vecs[3].nw = 3;
    vecs[3].w[0] = 64'h0807060504030201; vecs[3].w[1] = 64'h100F0E0D0C0B0A09;
    vecs[3].w[2] = 64'h1817161514131211;
    vecs[3].k = {8'hFF, 8'hFF, 8'hFF}; vecs[3].l = 3'b100;
    vecs[4].sel = 0; vecs[4].npix = 1; vecs[4].eof = 1; vecs[4].nw = 1;
    vecs[4].pix[0] = 24'hCCBBAA; vecs[4].w[0] = 64'h00CCBBAA; vecs[4].k[0] = 8'h07;
    vecs[4].l = 3'b001;
    vecs[5].sel = 2; vecs[5].npix = 4; vecs[5].eof = 1; vecs[5].nw = 1;
    for (int i = 0; i < 4; i++) vecs[5].pix[i] = {16'h0, 8'(8'hA1 + i)};
    vecs[5].w[0] = 64'hA4A3A2A1; vecs[5].k[0] = 8'h0F; vecs[5].l = 3'b001;

    do_reset;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      chk("reset_valid", 64'(ov[s]), 64'h0);
      chk("reset_last", 64'(ol[s]), 64'h0);
      chk("reset_keep", 64'(get_keep(s)), 64'h0);
      chk("reset_data", get_data(s), 64'h0);
      chk("reset_done", 64'(fd[s]), 64'h0);
      chk("reset_ready", 64'(rdy[s]), 64'h1);
    end
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      cur_sel = vecs[v].sel;
      do_reset;
      qb = q_data.size();
      fb = fd_cnt;
      out_ready = 1'b1;
      for (int i = 0; i < vecs[v].npix; i++)
        send(vecs[v].pix[i], vecs[v].eof && (i == vecs[v].npix - 1));
      drain_and_check_words(qb, vecs[v].nw, vecs[v].w, vecs[v].k, vecs[v].l);
      if (vecs[v].lat && (q_cyc.size() >= qb + vecs[v].nw))
        chk("last_word_latency", 64'(q_cyc[qb+vecs[v].nw-1]), 64'(last_acc));
      chk("frame_done_count", 64'(fd_cnt - fb), 64'(vecs[v].eof));
    end

    // Backpressure: word held stable for 5 stalled cycles, then resumes cleanly.
    cur_sel = 2;
    do_reset;
    qb = q_data.size();
    fb = fd_cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send({16'h0, 8'(i + 1)}, 1'b0);
    in_valid = 1'b1; in_gray = 8'h05; in_rgb = 24'h000005;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(rdy[2]), 64'h0);
      chk("bp_valid", 64'(ov[2]), 64'h1);
      chk("bp_data", get_data(2), 64'h04030201);
      chk("bp_keep", 64'(get_keep(2)), 64'h0F);
      chk("bp_last", 64'(ol[2]), 64'h0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(24'h05, 1'b0);
    send(24'h06, 1'b0);
    send(24'h07, 1'b0);
    send(24'h08, 1'b1);
    drain_and_check_words(qb, 2, {64'h0, 64'h08070605, 64'h04030201},
                          {8'h0, 8'h0F, 8'h0F}, 3'b010);
    chk("bp_frame_done", 64'(fd_cnt - fb), 64'h1);

    // Reset while stuck in FLUSH aborts the frame; next frame starts at lane 0.
    cur_sel = 1;
    do_reset;
    qb = q_data.size();
    fb = fd_cnt;
    out_ready = 1'b0;
    send(24'h030201, 1'b0);
    send(24'h060504, 1'b1);
    @(negedge clk);
    chk("flush_in_ready", 64'(rdy[1]), 64'h0);
    chk("flush_valid", 64'(ov[1]), 64'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("abort_valid", 64'(ov[1]), 64'h0);
    chk("abort_in_ready", 64'(rdy[1]), 64'h1);
    @(posedge clk);
    #1;
    send(24'h0C0B0A, 1'b1);
    drain_and_check_words(qb, 1, {64'h0, 64'h0, 64'h000A0B0C}, {8'h0, 8'h0, 8'h07}, 3'b001);
    chk("abort_frame_done", 64'(fd_cnt - fb), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
